// File: rtl/bp_pkg.sv
// -----------------------------------------------------------------------------
// bp_pkg
// Shared types and constants for the fetch-side predictor and the execute-side
// branch resolve unit.
//   BP_WIDTH   : default PC/target width of the predictor datapath
//   PC_STEP    : byte distance to the sequential (fall-through) instruction
//   bp_entry_t : one in-flight prediction {pc, taken, target, ld} at BP_WIDTH
// -----------------------------------------------------------------------------
package bp_pkg;

    localparam int BP_WIDTH = 32;
    localparam int PC_STEP  = 4;

    typedef struct packed {
        logic [BP_WIDTH-1:0] pc;
        logic                taken;
        logic [BP_WIDTH-1:0] target;
        logic                ld;
    } bp_entry_t;

endpackage

// File: rtl/bp_pred_fifo.sv
// -----------------------------------------------------------------------------
// bp_pred_fifo
// In-order storage for predictions issued at fetch and awaiting resolution.
// The caller guarantees it never pushes into a full FIFO without a pop and
// never pops an empty one; clear has priority over push and pop.
//   clk, rst     : clock, asynchronous active-low reset
//   push, wdata  : append wdata at the tail
//   pop          : retire the head entry
//   clear        : discard every entry (flush / wrong-path squash)
//   head         : oldest entry, valid while !empty
//   full, empty  : registered occupancy flags for the current pointer state
// -----------------------------------------------------------------------------
module bp_pred_fifo #(
    parameter int DATA_W = 66,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic              clear,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when the index
    // bits are equal.
    logic [AW:0]       wr_ptr, rd_ptr;
    logic [AW:0]       wr_ptr_nxt, rd_ptr_nxt;
    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: every variable assigned in always_comb gets a default first, so
    // no path can leave it unassigned and infer a latch.
    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (clear) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + (AW+1)'(1);
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            full   <= (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
            empty  <= (wr_ptr_nxt == rd_ptr_nxt);
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers alone
    // define which slots hold live data, so the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= wdata;
    end

    assign head = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// branch_resolve_unit
// Matches each prediction issued at fetch against the branch outcome resolved
// in EX, in program order. Produces the predictor/loop-detector training
// update, a fetch redirect on mispredict, saturating accuracy counters and
// sticky protocol-error flags.
//   clk, rst                  : clock, asynchronous active-low reset
//   pred_*_F                  : prediction issued at fetch (pc/taken/target/ld)
//   flush                     : external flush, kills all in-flight entries
//   res_*_EX                  : resolved branch (pc/taken/target)
//   full, empty               : prediction FIFO occupancy (registered)
//   upd_valid/pc/taken/ld_clr : training update, one cycle after resolution
//   redirect_valid/pc         : mispredict redirect, one cycle after resolution
//   resolved_cnt, mispred_cnt, ld_mispred_cnt : saturating statistics
//   err_seq, err_ovf          : sticky sequencing / overflow errors
// -----------------------------------------------------------------------------
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pred_valid_F,
    input  logic [WIDTH-1:0] pred_pc_F,
    input  logic             pred_taken_F,
    input  logic [WIDTH-1:0] pred_target_F,
    input  logic             pred_ld_F,
    input  logic             flush,
    input  logic             res_valid_EX,
    input  logic [WIDTH-1:0] res_pc_EX,
    input  logic             res_taken_EX,
    input  logic [WIDTH-1:0] res_target_EX,
    output logic             full,
    output logic             empty,
    output logic             upd_valid,
    output logic [WIDTH-1:0] upd_pc,
    output logic             upd_taken,
    output logic             upd_ld_clr,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic [CNT_W-1:0] resolved_cnt,
    output logic [CNT_W-1:0] mispred_cnt,
    output logic [CNT_W-1:0] ld_mispred_cnt,
    output logic             err_seq,
    output logic             err_ovf
);

    // Same field layout as bp_entry_t, sized to this instance's WIDTH.
    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic             taken;
        logic [WIDTH-1:0] target;
        logic             ld;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    entry_t             wr_entry;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_bits;

    logic             do_pop;
    logic             pc_mismatch;
    logic             mispredict;
    logic             fifo_push;
    logic             fifo_clear;
    logic             seq_err;
    logic             ovf_err;
    logic [WIDTH-1:0] corrected_pc;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign wr_entry = '{pc:     pred_pc_F,
                        taken:  pred_taken_F,
                        target: pred_target_F,
                        ld:     pred_ld_F};

    bp_pred_fifo #(
        .DATA_W (ENTRY_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (do_pop),
        .clear (fifo_clear),
        .wdata (wr_entry),
        .head  (head_bits),
        .full  (full),
        .empty (empty)
    );

    assign head_entry = entry_t'(head_bits);

    always_comb begin
        do_pop      = res_valid_EX && !empty && !flush;
        pc_mismatch = (head_entry.pc != res_pc_EX);
        mispredict  = do_pop &&
                      ((head_entry.taken != res_taken_EX) ||
                       (res_taken_EX && (head_entry.target != res_target_EX)) ||
                       pc_mismatch);
        // A mispredict squashes everything younger, including a prediction
        // arriving this very cycle, which is wrong-path and not an overflow.
        fifo_push   = pred_valid_F && !flush && !mispredict && (!full || do_pop);
        fifo_clear  = flush || mispredict;
        seq_err     = !flush && res_valid_EX && (empty || pc_mismatch);
        ovf_err     = !flush && pred_valid_F && full && !do_pop;
        corrected_pc = res_taken_EX ? res_target_EX
                                    : res_pc_EX + WIDTH'(PC_STEP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            upd_valid      <= 1'b0;
            upd_pc         <= '0;
            upd_taken      <= 1'b0;
            upd_ld_clr     <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            resolved_cnt   <= '0;
            mispred_cnt    <= '0;
            ld_mispred_cnt <= '0;
            err_seq        <= 1'b0;
            err_ovf        <= 1'b0;
        end else begin
            upd_valid      <= do_pop;
            upd_ld_clr     <= mispredict && head_entry.ld;
            redirect_valid <= mispredict;
            if (do_pop) begin
                upd_pc       <= res_pc_EX;
                upd_taken    <= res_taken_EX;
                resolved_cnt <= sat_inc(resolved_cnt);
            end
            if (mispredict) begin
                redirect_pc <= corrected_pc;
                mispred_cnt <= sat_inc(mispred_cnt);
                if (head_entry.ld) ld_mispred_cnt <= sat_inc(ld_mispred_cnt);
            end
            if (seq_err) err_seq <= 1'b1;
            if (ovf_err) err_ovf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_unit
// Directed scenarios with literal expectations followed by randomized traffic,
// all compared every cycle against a queue-based model of the resolve unit.
// -----------------------------------------------------------------------------
module tb_branch_resolve_unit;
    import bp_pkg::*;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             pred_valid_F;
    logic [WIDTH-1:0] pred_pc_F;
    logic             pred_taken_F;
    logic [WIDTH-1:0] pred_target_F;
    logic             pred_ld_F;
    logic             flush;
    logic             res_valid_EX;
    logic [WIDTH-1:0] res_pc_EX;
    logic             res_taken_EX;
    logic [WIDTH-1:0] res_target_EX;
    logic             full;
    logic             empty;
    logic             upd_valid;
    logic [WIDTH-1:0] upd_pc;
    logic             upd_taken;
    logic             upd_ld_clr;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_pc;
    logic [CNT_W-1:0] resolved_cnt;
    logic [CNT_W-1:0] mispred_cnt;
    logic [CNT_W-1:0] ld_mispred_cnt;
    logic             err_seq;
    logic             err_ovf;

    branch_resolve_unit #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pred_valid_F   (pred_valid_F),
        .pred_pc_F      (pred_pc_F),
        .pred_taken_F   (pred_taken_F),
        .pred_target_F  (pred_target_F),
        .pred_ld_F      (pred_ld_F),
        .flush          (flush),
        .res_valid_EX   (res_valid_EX),
        .res_pc_EX      (res_pc_EX),
        .res_taken_EX   (res_taken_EX),
        .res_target_EX  (res_target_EX),
        .full           (full),
        .empty          (empty),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .upd_ld_clr     (upd_ld_clr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .resolved_cnt   (resolved_cnt),
        .mispred_cnt    (mispred_cnt),
        .ld_mispred_cnt (ld_mispred_cnt),
        .err_seq        (err_seq),
        .err_ovf        (err_ovf)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // ---------------- behavioural model ----------------
    bp_entry_t   q[$];
    bit          e_upd_valid, e_upd_taken, e_ld_clr, e_rv, e_err_seq, e_err_ovf;
    logic [31:0] e_upd_pc, e_rpc;
    int          e_resolved, e_mispred, e_ld_mispred;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        e_upd_valid = 0; e_upd_taken = 0; e_ld_clr = 0; e_rv = 0;
        e_err_seq = 0; e_err_ovf = 0;
        e_upd_pc = '0; e_rpc = '0;
        e_resolved = 0; e_mispred = 0; e_ld_mispred = 0;
    endtask

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // Applies the inputs that were just sampled by the clock edge.
    task automatic model_cycle();
        bp_entry_t h;
        bit        had_room;
        bit        popped;
        bit        mp;
        bp_entry_t ne;
        e_upd_valid = 0;
        e_ld_clr    = 0;
        e_rv        = 0;
        if (flush) begin
            q.delete();
        end else begin
            had_room = (q.size() < DEPTH);
            popped   = res_valid_EX && (q.size() != 0);
            mp       = 0;
            if (res_valid_EX && q.size() == 0) e_err_seq = 1;
            if (popped) begin
                h  = q.pop_front();
                mp = (h.taken != res_taken_EX) ||
                     (res_taken_EX && h.target != res_target_EX) ||
                     (h.pc != res_pc_EX);
                if (h.pc != res_pc_EX) e_err_seq = 1;
                e_upd_valid = 1;
                e_upd_pc    = res_pc_EX;
                e_upd_taken = res_taken_EX;
                e_resolved  = sat(e_resolved);
                if (mp) begin
                    e_rv      = 1;
                    e_rpc     = res_taken_EX ? res_target_EX : res_pc_EX + 32'd4;
                    e_mispred = sat(e_mispred);
                    if (h.ld) begin
                        e_ld_clr     = 1;
                        e_ld_mispred = sat(e_ld_mispred);
                    end
                    q.delete();
                end
            end
            if (pred_valid_F && !mp) begin
                if (had_room || popped) begin
                    ne = '{pc: pred_pc_F, taken: pred_taken_F,
                           target: pred_target_F, ld: pred_ld_F};
                    q.push_back(ne);
                end else begin
                    e_err_ovf = 1;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("empty",          empty,          q.size() == 0);
            check("full",           full,           q.size() == DEPTH);
            check("upd_valid",      upd_valid,      e_upd_valid);
            check("upd_ld_clr",     upd_ld_clr,     e_ld_clr);
            check("redirect_valid", redirect_valid, e_rv);
            if (e_upd_valid) begin
                check("upd_pc",    upd_pc,    e_upd_pc);
                check("upd_taken", upd_taken, e_upd_taken);
            end
            if (e_rv) check("redirect_pc", redirect_pc, e_rpc);
            check("resolved_cnt",   resolved_cnt,   e_resolved);
            check("mispred_cnt",    mispred_cnt,    e_mispred);
            check("ld_mispred_cnt", ld_mispred_cnt, e_ld_mispred);
            check("err_seq",        err_seq,        e_err_seq);
            check("err_ovf",        err_ovf,        e_err_ovf);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        pred_valid_F = 0; pred_pc_F = '0; pred_taken_F = 0;
        pred_target_F = '0; pred_ld_F = 0; flush = 0;
        res_valid_EX = 0; res_pc_EX = '0; res_taken_EX = 0; res_target_EX = '0;
    endtask

    // Lets the next edge sample the current inputs, then updates the model.
    task automatic step();
        @(posedge clk);
        #1;
        model_cycle();
    endtask

    task automatic drive(input bit pv, input logic [31:0] ppc, input bit pt,
                         input logic [31:0] ptg, input bit pld, input bit fl,
                         input bit rv, input logic [31:0] rpc, input bit rt,
                         input logic [31:0] rtg);
        pred_valid_F = pv; pred_pc_F = ppc; pred_taken_F = pt;
        pred_target_F = ptg; pred_ld_F = pld; flush = fl;
        res_valid_EX = rv; res_pc_EX = rpc; res_taken_EX = rt; res_target_EX = rtg;
        step();
        idle();
    endtask

    task automatic push(input logic [31:0] pc, input bit t, input logic [31:0] tg,
                        input bit ld);
        drive(1, pc, t, tg, ld, 0, 0, 0, 0, 0);
    endtask

    task automatic resolve(input logic [31:0] pc, input bit t, input logic [31:0] tg);
        drive(0, 0, 0, 0, 0, 0, 1, pc, t, tg);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset(input string tag);
        idle();
        #2;
        rst = 0;
        #1;
        model_reset();
        check({tag, "_empty"},     empty,          1);
        check({tag, "_full"},      full,           0);
        check({tag, "_upd_valid"}, upd_valid,      0);
        check({tag, "_redirect"},  redirect_valid, 0);
        check({tag, "_resolved"},  resolved_cnt,   0);
        check({tag, "_mispred"},   mispred_cnt,    0);
        check({tag, "_err_seq"},   err_seq,        0);
        check({tag, "_err_ovf"},   err_ovf,        0);
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic random_cycle();
        bp_entry_t h;
        idle();
        if ($urandom_range(0, 99) < 50) begin
            pred_valid_F  = 1;
            pred_pc_F     = 32'($urandom_range(0, 255)) << 2;
            pred_taken_F  = 1'($urandom_range(0, 1));
            pred_target_F = 32'($urandom_range(0, 255)) << 2;
            pred_ld_F     = 1'($urandom_range(0, 1));
        end
        flush = ($urandom_range(0, 99) < 3);
        if ($urandom_range(0, 99) < 45) begin
            res_valid_EX = 1;
            if (q.size() != 0 && $urandom_range(0, 99) < 85) begin
                h = q[0];
                res_pc_EX     = h.pc;
                res_taken_EX  = ($urandom_range(0, 99) < 80) ? h.taken : !h.taken;
                res_target_EX = ($urandom_range(0, 99) < 85) ? h.target
                                : 32'($urandom_range(0, 255)) << 2;
            end else begin
                res_pc_EX     = 32'($urandom_range(0, 255)) << 2;
                res_taken_EX  = 1'($urandom_range(0, 1));
                res_target_EX = 32'($urandom_range(0, 255)) << 2;
            end
        end
        step();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        idle();
        rst = 0;
        model_reset();
        chk_en = 1;
        #12;
        check("rst_empty",   empty,          1);
        check("rst_full",    full,           0);
        check("rst_upd",     upd_valid,      0);
        check("rst_redir",   redirect_valid, 0);
        check("rst_counter", resolved_cnt,   0);
        check("rst_err",     {err_seq, err_ovf}, 0);
        @(posedge clk);
        #1;
        rst = 1;

        // 1: correct not-taken prediction
        push(32'h100, 0, 0, 0);
        resolve(32'h100, 0, 0);
        check("t1_upd_valid", upd_valid,      1);
        check("t1_upd_pc",    upd_pc,         32'h100);
        check("t1_upd_taken", upd_taken,      0);
        check("t1_redirect",  redirect_valid, 0);
        check("t1_resolved",  resolved_cnt,   1);
        check("t1_mispred",   mispred_cnt,    0);

        // 2: loop-detector taken prediction resolved not-taken
        push(32'h200, 1, 32'h180, 1);
        resolve(32'h200, 0, 0);
        check("t2_redirect",    redirect_valid, 1);
        check("t2_redirect_pc", redirect_pc,    32'h204);
        check("t2_ld_clr",      upd_ld_clr,     1);
        check("t2_ld_mispred",  ld_mispred_cnt, 1);
        check("t2_mispred",     mispred_cnt,    1);
        step();
        check("t2_pulse", redirect_valid, 0);

        // 3: mispredict squashes younger entries
        push(32'h10, 0, 0, 0);
        push(32'h20, 0, 0, 0);
        push(32'h30, 0, 0, 0);
        resolve(32'h10, 1, 32'h400);
        check("t3_empty",       empty,       1);
        check("t3_redirect_pc", redirect_pc, 32'h400);
        check("t3_err_before",  err_seq,     0);
        resolve(32'h20, 0, 0);
        check("t3_err_seq",  err_seq,      1);
        check("t3_no_upd",   upd_valid,    0);
        check("t3_resolved", resolved_cnt, 3);

        // 4: full FIFO, push+pop vs push alone
        push(32'h40, 0, 0, 0);
        push(32'h50, 0, 0, 0);
        push(32'h60, 0, 0, 0);
        push(32'h70, 0, 0, 0);
        check("t4_full", full, 1);
        drive(1, 32'h80, 0, 0, 0, 0, 1, 32'h40, 0, 0);
        check("t4_full_pp", full,    1);
        check("t4_no_ovf",  err_ovf, 0);
        push(32'h90, 0, 0, 0);
        check("t4_ovf",      err_ovf, 1);
        check("t4_full_ovf", full,    1);
        resolve(32'h50, 0, 0);
        resolve(32'h60, 0, 0);
        resolve(32'h70, 0, 0);
        resolve(32'h80, 0, 0);
        check("t4_drained",  empty,          1);
        check("t4_no_redir", redirect_valid, 0);
        check("t4_resolved", resolved_cnt,   8);

        // 5: flush beats simultaneous push and resolve
        push(32'hA0, 0, 0, 0);
        drive(1, 32'hB0, 0, 0, 0, 1, 1, 32'hA0, 0, 0);
        check("t5_empty",    empty,        1);
        check("t5_no_upd",   upd_valid,    0);
        check("t5_resolved", resolved_cnt, 8);
        check("t5_mispred",  mispred_cnt,  2);

        // 6: counters saturate at all-ones
        for (int i = 0; i < 300; i++) begin
            push(32'h1000 + 32'(i) * 4, 0, 0, 0);
            resolve(32'h1000 + 32'(i) * 4, 1, 32'h2000);
        end
        check("t6_mispred_sat",  mispred_cnt,  CMAX);
        check("t6_resolved_sat", resolved_cnt, CMAX);
        step();
        check("t6_mispred_hold", mispred_cnt,  CMAX);

        // 7: asynchronous reset with entries and a strobe in flight
        push(32'h300, 0, 0, 0);
        push(32'h304, 0, 0, 0);
        pred_valid_F = 1; pred_pc_F = 32'h308;
        res_valid_EX = 1; res_pc_EX = 32'h300;
        step();
        check("t7_upd_before", upd_valid, 1);
        do_reset("t7");

        // 8: randomized traffic with a reset in the middle
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset("t8");
            else random_cycle();
        end
        idle();
        step();
        chk_en = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-side companion to the fetch-stage loop detector and branch predictor. Records every prediction issued at fetch in a small in-order FIFO, matches it against the branch outcome resolved in EX, and produces the predictor/loop-detector training update (PC, actual direction, counter-reset request), a pipeline redirect on mispredict, and saturating accuracy counters.

## Interface

- `WIDTH`, 32, PC/target width
- `DEPTH`, 4, in-flight prediction entries; power of two, at least 2
- `CNT_W`, 16, statistics counter width

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `pred_valid_F`  in  1  fetch issued a branch prediction this cycle
- `pred_pc_F`  in  WIDTH  PC of predicted branch
- `pred_taken_F`  in  1  predicted direction
- `pred_target_F`  in  WIDTH  predicted target; meaningful when taken
- `pred_ld_F`  in  1  prediction came from loop detector (its `LD_en` was high)
- `flush`  in  1  external pipeline flush (trap/jump); kills all in-flight entries
- `res_valid_EX`  in  1  a branch resolved in EX this cycle
- `res_pc_EX`  in  WIDTH  PC of resolved branch
- `res_taken_EX`  in  1  actual direction (ALU feedback)
- `res_target_EX`  in  WIDTH  actual taken target
- `full`  out  1  FIFO holds DEPTH entries
- `empty`  out  1  FIFO holds 0 entries
- `upd_valid`  out  1  training update strobe (drives loop detector `branch_en_EX`)
- `upd_pc`  out  WIDTH  PC to train (drives `PC_EX`)
- `upd_taken`  out  1  actual direction (drives `feedback_from_ALU`)
- `upd_ld_clr`  out  1  loop-detector-sourced prediction was wrong; clear its loop entry
- `redirect_valid`  out  1  mispredict; fetch must restart at `redirect_pc`
- `redirect_pc`  out  WIDTH  corrected fetch PC
- `resolved_cnt`  out  CNT_W  branches resolved
- `mispred_cnt`  out  CNT_W  mispredicts
- `ld_mispred_cnt`  out  CNT_W  mispredicts on loop-detector predictions
- `err_seq`  out  1  sticky: PC order mismatch or resolve with empty FIFO
- `err_ovf`  out  1  sticky: push while full without simultaneous pop

## Operation

- Entry = {pc, taken, target, ld}. Read/write pointers are log2(DEPTH)+1 bits; full = MSBs differ, low bits equal; empty = pointers equal.
- Push when `pred_valid_F` and (not full or a pop occurs the same cycle). Push while full without pop: dropped, `err_ovf` set.
- Pop when `res_valid_EX` and not empty. Resolve with empty FIFO: no update, no redirect, `err_seq` set.
- On pop, compare head to the resolution:
  - mispredict = (head.taken != res_taken_EX) or (res_taken_EX and head.target != res_target_EX) or (head.pc != res_pc_EX).
  - A PC mismatch also sets `err_seq`.
  - `redirect_pc` = res_target_EX if taken, else res_pc_EX + 4 (modulo 2^WIDTH).
  - `upd_ld_clr` = mispredict and head.ld.
- A mispredict empties the FIFO: younger entries are wrong-path. A push in the same cycle is discarded without setting `err_ovf`.
- `flush` has highest priority: pointers are cleared, and push and pop that cycle are ignored (no update, no counters).
- Counters saturate at all-ones. `resolved_cnt` increments per pop. `mispred_cnt` and `ld_mispred_cnt` increment per qualifying mispredict.

## Timing

- Reset: pointers 0, `empty`=1, `full`=0. All other outputs are 0, including counters and error flags.
- `full` and `empty` are registered and reflect the pointer state after the previous edge.
- `upd_*`, `redirect_*` and counters are registered, one cycle after the `res_valid_EX` edge. Strobes are single-cycle pulses.
- A pop and a push in the same cycle on a non-empty FIFO both take effect; occupancy is unchanged.
- A push into an empty FIFO becomes the head at the next edge. It may be resolved no earlier than the following cycle.
- An asynchronous reset mid-operation discards all entries and pending strobes immediately.

## Structure

- Shared package `bp_pkg`: `bp_entry_t` struct {pc, taken, target, ld}, `PC_STEP` = 4.
- Sub-module `bp_pred_fifo`: parameterized storage and pointer logic, with push/pop/clear, head output, full/empty.
- Top level holds the compare/redirect logic, output registers, counters and sticky flags.

## Test plan

- Push PC 0x100 not-taken, resolve 0x100 not-taken → `upd_valid`=1, `upd_taken`=0, no redirect; `resolved_cnt`=1, `mispred_cnt`=0.
- Push 0x200 taken→0x180 (ld=1), resolve not-taken → `redirect_pc`=0x204, `upd_ld_clr`=1, `ld_mispred_cnt`=1.
- Push 0x10, 0x20, 0x30; mispredict on 0x10 → `empty`=1 next cycle; a later resolve sets `err_seq`.
- Fill 4 entries; push+pop together keeps `full`=1 with no `err_ovf`; push alone while full → `err_ovf`=1 and the entry is dropped.
- Assert `flush` together with a push and a resolve → `empty`=1, no `upd_valid`, counters unchanged.
- Force `mispred_cnt` to 0xFFFF and cause a mispredict → value stays 0xFFFF. Assert `rst` mid-stream → all outputs return to reset values.
